pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter NSTG, default 3, number of tracked stages after ID, range 2..8; stage 1 is EX and stage NSTG is WB.
REQ-004 SHALL have parameter LD_STG, default 2, range 1..NSTG-1; this is the first stage at which load data is valid.
REQ-005 SHALL use one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-006 Ports, in order (name direction width meaning):
- clk in 1 clock
- rst in 1 sync active-high reset
- id_valid in 1 ID holds a real instruction
- id_rs in AW source A address
- id_rt in AW source B address
- id_use_rs in 1 instruction reads rs
- id_use_rt in 1 instruction reads rt
- id_early in 1 operands consumed in ID (branch/jr compare)
- id_wr_en in 1 instruction writes a register
- id_wr_addr in AW destination address
- id_is_load in 1 result comes from memory
- id_redirect in 1 taken branch/jump resolved in ID
- exc in 1 exception flush
- stg_data in NSTG*DATA_W result of stage k in slice k-1
- rs_rf in DATA_W register-file read A
- rt_rf in DATA_W register-file read B
- rs_val out DATA_W forwarded operand A
- rt_val out DATA_W forwarded operand B
- hold out 1 freeze PC and IF/ID
- bubble out 1 insert NOP into ID/EX
- flush_ifid out 1 clear IF/ID
- stg_valid out NSTG per-stage valid
- stall_cnt out 32 saturating stall-cycle count
- flush_cnt out 32 saturating flush count

Function
REQ-007 SHALL keep a per-stage scoreboard entry: valid, wr_en, wr_addr, rdy. rdy = LD_STG for loads, else 1.
REQ-008 Every cycle, entry k SHALL shift to k+1 (k<NSTG). The entry at NSTG retires.
REQ-009 Stage 1 SHALL load the ID instruction when id_valid & ~bubble; otherwise it SHALL load an invalid entry.
REQ-010 Per operand (used, addr!=0): the matching entry SHALL be the youngest (lowest k) that is valid, has wr_en, and has wr_addr==addr.
REQ-011 The matching entry SHALL be ready when k >= rdy, or k > rdy if id_early.
REQ-012 On a ready match, the operand SHALL be stg_data slice k. With no match, or addr 0, or operand unused, it SHALL be the RF value. All of this is combinational, with zero latency.
REQ-013 An unready match for either operand SHALL set hazard. hold = bubble = hazard & id_valid & ~exc.
REQ-014 flush_ifid SHALL equal exc | (id_redirect & id_valid & ~hazard).
REQ-015 exc SHALL also force bubble, overriding hold.
REQ-016 A redirect under hazard SHALL be ignored until the stall clears; the instruction is re-evaluated with forwarded operands.
REQ-017 A hazard SHALL persist every cycle until the producer reaches stage rdy (or rdy+1 if id_early). Stall length SHALL equal rdy-k (+1 if id_early).
REQ-018 stall_cnt SHALL increment on each cycle with hold=1. flush_cnt SHALL increment on each cycle with flush_ifid=1. Both saturate at 32'hFFFF_FFFF.
REQ-019 stg_valid[k-1] SHALL reflect the registered valid of entry k.
REQ-020 An instruction with id_wr_en and id_wr_addr==0 SHALL enter with wr_en cleared.
REQ-021 When entries at two stages match, only the youngest SHALL be used, even if it is unready and an older one is ready.

Reset
REQ-022 On rst=1 at a clock edge, all entries SHALL become invalid and both counters SHALL become 0.
REQ-023 The same holds for rst asserted mid-stall: there is no residual hold on the next cycle.
REQ-024 While rst=1, outputs SHALL be combinational from inputs and the cleared scoreboard: hold=0, and rs_val/rt_val equal rs_rf/rt_rf.

Verification (default parameters)
REQ-025 ALU write $8, then next instruction reads $8: no hold; rs_val = stg_data stage 1 in the ID cycle.
REQ-026 lw $9, then next instruction reads $9: exactly 1 cycle of hold=bubble=1; then rs_val = stage 2 data; stall_cnt=1.
REQ-027 ALU $10, then beq reading $10 with id_early=1: 1 stall cycle; then forward from stage 2; a taken redirect raises flush_ifid one cycle, and flush_cnt=1.
REQ-028 Writes to $5 at stages 2 and 3 with different data: rs_val takes the stage-2 value. A $0 producer and $0 reader: never a hazard, and rs_val=rs_rf.
REQ-029 Load-use hazard with exc=1 in the same cycle: hold=0, bubble=1, flush_ifid=1.
REQ-030 rst during a 1-cycle stall, next cycle same operands: hold=0, stg_valid=0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based forwarding and interlock unit for an in-order pipeline.
// Tracks destination and readiness for the NSTG stages after ID and resolves ID operands.
module pipe_hazard_unit #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NSTG   = 3,
    parameter int LD_STG = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [AW-1:0]          id_rs,
    input  logic [AW-1:0]          id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_early,
    input  logic                   id_wr_en,
    input  logic [AW-1:0]          id_wr_addr,
    input  logic                   id_is_load,
    input  logic                   id_redirect,
    input  logic                   exc,
    input  logic [NSTG*DATA_W-1:0] stg_data,
    input  logic [DATA_W-1:0]      rs_rf,
    input  logic [DATA_W-1:0]      rt_rf,
    output logic [DATA_W-1:0]      rs_val,
    output logic [DATA_W-1:0]      rt_val,
    output logic                   hold,
    output logic                   bubble,
    output logic                   flush_ifid,
    output logic [NSTG-1:0]        stg_valid,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            flush_cnt
);
    localparam int RW = 4;

    logic [NSTG-1:0]    valid_r;
    logic [NSTG-1:0]    wr_en_r;
    logic [NSTG*AW-1:0] wr_addr_r;
    logic [NSTG*RW-1:0] rdy_r;
    logic               rs_stall_s;
    logic               rt_stall_s;
    logic               hazard_s;
    logic               load_s;

    // Youngest matching producer decides; scanning oldest-first lets it overwrite.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic                   use_op,
        input logic [AW-1:0]          addr,
        input logic [DATA_W-1:0]      rf_val,
        input logic                   early,
        input logic                   clr,
        input logic [NSTG-1:0]        v,
        input logic [NSTG-1:0]        we,
        input logic [NSTG*AW-1:0]     wa,
        input logic [NSTG*RW-1:0]     rd,
        input logic [NSTG*DATA_W-1:0] data
    );
        logic [DATA_W-1:0] val;
        logic              stall;
        int                need;
        val   = rf_val;
        stall = 1'b0;
        for (int i = NSTG - 1; i >= 0; i--) begin
            need = int'(rd[i*RW +: RW]) + int'(early);
            if (use_op && (addr != {AW{1'b0}}) && !clr && v[i] && we[i] &&
                (wa[i*AW +: AW] == addr)) begin
                if (i + 1 >= need) begin
                    val   = data[i*DATA_W +: DATA_W];
                    stall = 1'b0;
                end else begin
                    val   = rf_val;
                    stall = 1'b1;
                end
            end
        end
        return {stall, val};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        return (en && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
    endfunction

    assign {rs_stall_s, rs_val} = fwd_lookup(id_use_rs, id_rs, rs_rf, id_early, rst,
                                             valid_r, wr_en_r, wr_addr_r, rdy_r, stg_data);
    assign {rt_stall_s, rt_val} = fwd_lookup(id_use_rt, id_rt, rt_rf, id_early, rst,
                                             valid_r, wr_en_r, wr_addr_r, rdy_r, stg_data);

    // An exception squashes the ID instruction, so it wins over the interlock.
    assign hazard_s   = rs_stall_s | rt_stall_s;
    assign hold       = hazard_s & id_valid & ~exc;
    assign bubble     = hold | exc;
    assign flush_ifid = exc | (id_redirect & id_valid & ~hazard_s);
    assign load_s     = id_valid & ~bubble;
    assign stg_valid  = valid_r;

    // Scoreboard shift register: ID enters stage 1, stage NSTG retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r   <= {NSTG{1'b0}};
            wr_en_r   <= {NSTG{1'b0}};
            wr_addr_r <= {(NSTG*AW){1'b0}};
            rdy_r     <= {(NSTG*RW){1'b0}};
        end else begin
            valid_r   <= {valid_r[NSTG-2:0], load_s};
            wr_en_r   <= {wr_en_r[NSTG-2:0], id_wr_en & (id_wr_addr != {AW{1'b0}})};
            wr_addr_r <= {wr_addr_r[(NSTG-1)*AW-1:0], id_wr_addr};
            rdy_r     <= {rdy_r[(NSTG-1)*RW-1:0], id_is_load ? RW'(LD_STG) : 4'd1};
        end
    end

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, hold);
            flush_cnt <= sat_inc(flush_cnt, flush_ifid);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: per-cycle comparison against an in-flight
// instruction model plus hand-computed literal expectations for key scenarios.
module tb_pipe_hazard_unit;
    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int NSTG   = 3;
    localparam int LD_STG = 2;

    logic                   clk;
    logic                   rst;
    logic                   id_valid, id_use_rs, id_use_rt, id_early;
    logic                   id_wr_en, id_is_load, id_redirect, exc;
    logic [AW-1:0]          id_rs, id_rt, id_wr_addr;
    logic [NSTG*DATA_W-1:0] stg_data;
    logic [DATA_W-1:0]      rs_rf, rt_rf, rs_val, rt_val;
    logic                   hold, bubble, flush_ifid;
    logic [NSTG-1:0]        stg_valid;
    logic [31:0]            stall_cnt, flush_cnt;

    pipe_hazard_unit #(.DATA_W(DATA_W), .AW(AW), .NSTG(NSTG), .LD_STG(LD_STG)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_early(id_early),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .id_redirect(id_redirect), .exc(exc), .stg_data(stg_data),
        .rs_rf(rs_rf), .rt_rf(rt_rf), .rs_val(rs_val), .rt_val(rt_val),
        .hold(hold), .bubble(bubble), .flush_ifid(flush_ifid),
        .stg_valid(stg_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: what sits in each stage (dst 0 = writes nothing) and when its result exists.
    bit          m_valid [1:NSTG];
    logic [4:0]  m_dst   [1:NSTG];
    int          m_lat   [1:NSTG];
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;
    bit          m_hold_now;

    logic [31:0] obs_rs, obs_rt, obs_stall, obs_flush_cnt;
    logic        obs_hold, obs_bubble, obs_flush;
    logic [2:0]  obs_sv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void lookup(input logic use_op, input logic [4:0] a,
                                   input logic [31:0] rf, output logic [31:0] val,
                                   output bit stall);
        val   = rf;
        stall = 1'b0;
        if (use_op && a != 5'd0 && !rst) begin
            for (int k = 1; k <= NSTG; k++) begin
                if (m_valid[k] && m_dst[k] == a) begin
                    if (k >= m_lat[k] + (id_early ? 1 : 0)) val = stg_data[(k-1)*32 +: 32];
                    else stall = 1'b1;
                    break;
                end
            end
        end
    endfunction

    task automatic cycle();
        logic [31:0] e_rs, e_rt;
        bit          s_rs, s_rt, haz, e_hold, e_bubble, e_flush;
        logic [2:0]  e_sv;
        @(negedge clk);
        lookup(id_use_rs, id_rs, rs_rf, e_rs, s_rs);
        lookup(id_use_rt, id_rt, rt_rf, e_rt, s_rt);
        haz      = s_rs | s_rt;
        e_hold   = haz && id_valid && !exc;
        e_bubble = e_hold || exc;
        e_flush  = exc || (id_redirect && id_valid && !haz);
        for (int k = 1; k <= NSTG; k++) e_sv[k-1] = m_valid[k];
        check("rs_val", rs_val, e_rs);
        check("rt_val", rt_val, e_rt);
        check("hold", {31'd0, hold}, {31'd0, e_hold});
        check("bubble", {31'd0, bubble}, {31'd0, e_bubble});
        check("flush_ifid", {31'd0, flush_ifid}, {31'd0, e_flush});
        check("stg_valid", {29'd0, stg_valid}, {29'd0, e_sv});
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        obs_rs = rs_val; obs_rt = rt_val; obs_hold = hold; obs_bubble = bubble;
        obs_flush = flush_ifid; obs_sv = stg_valid; obs_stall = stall_cnt;
        obs_flush_cnt = flush_cnt;
        m_hold_now = e_hold;
        @(posedge clk);
        if (rst) begin
            for (int k = 1; k <= NSTG; k++) m_valid[k] = 1'b0;
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else begin
            if (e_hold && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (e_flush && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
            for (int k = NSTG; k >= 2; k--) begin
                m_valid[k] = m_valid[k-1];
                m_dst[k]   = m_dst[k-1];
                m_lat[k]   = m_lat[k-1];
            end
            m_valid[1] = id_valid && !e_bubble;
            m_dst[1]   = id_wr_en ? id_wr_addr : 5'd0;
            m_lat[1]   = id_is_load ? LD_STG : 1;
        end
        #1;
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_early = 1'b0; id_wr_en = 1'b0; id_wr_addr = 5'd0; id_is_load = 1'b0;
        id_redirect = 1'b0; exc = 1'b0;
    endtask

    task automatic set_instr(input logic [4:0] rs_a, input logic [4:0] rt_a, input bit urs,
                             input bit urt, input bit early, input bit we, input logic [4:0] wa,
                             input bit ld, input bit redir, input bit ex);
        id_valid = 1'b1; id_rs = rs_a; id_rt = rt_a; id_use_rs = urs; id_use_rt = urt;
        id_early = early; id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
        id_redirect = redir; exc = ex;
    endtask

    // Present an instruction and keep it in ID while the model says it is held.
    task automatic run_instr(input logic [4:0] rs_a, input logic [4:0] rt_a, input bit urs,
                             input bit urt, input bit early, input bit we, input logic [4:0] wa,
                             input bit ld, input bit redir, input bit ex, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        set_instr(rs_a, rt_a, urs, urt, early, we, wa, ld, redir, ex);
        for (int c = 0; c < 8 && !done; c++) begin
            cycle();
            if (m_hold_now) n++;
            else done = 1'b1;
        end
        if (!done) begin
            total++;
            $display("FAIL stall_bound: hold still 1 after 8 cycles, required release");
        end
        set_idle();
    endtask

    task automatic idle_cycle();
        set_idle();
        cycle();
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    int n;

    initial begin
        rst      = 1'b1;
        set_idle();
        rs_rf    = 32'hC0DE_0001;
        rt_rf    = 32'hC0DE_0002;
        stg_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
        for (int k = 1; k <= NSTG; k++) begin
            m_valid[k] = 1'b0; m_dst[k] = 5'd0; m_lat[k] = 1;
        end

        do_reset();
        check("reset_stg_valid", {29'd0, obs_sv}, 32'd0);
        check("reset_stall_cnt", obs_stall, 32'd0);

        // ALU producer then dependent reader: forwarded from stage 1, no stall
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd8, 0, 0, 0, n);
        run_instr(5'd8, 5'd3, 1, 1, 0, 1, 5'd12, 0, 0, 0, n);
        check("alu_use_holds", n, 32'd0);
        check("alu_use_rs", obs_rs, 32'hA000_0001);

        // load-use: one stall then forward from stage 2
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd9, 1, 0, 0, n);
        run_instr(5'd9, 5'd0, 1, 0, 0, 1, 5'd13, 0, 0, 0, n);
        check("load_use_holds", n, 32'd1);
        check("load_use_rs", obs_rs, 32'hA000_0002);
        check("load_use_stall_cnt", obs_stall, 32'd1);

        // early-compare branch after ALU: one stall, then taken redirect flushes
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd10, 0, 0, 0, n);
        run_instr(5'd10, 5'd0, 1, 1, 1, 0, 5'd0, 0, 1, 0, n);
        check("branch_holds", n, 32'd1);
        check("branch_rs", obs_rs, 32'hA000_0002);
        check("branch_flush", {31'd0, obs_flush}, 32'd1);
        idle_cycle();
        check("branch_flush_cnt", obs_flush_cnt, 32'd1);
        check("branch_stall_cnt", obs_stall, 32'd1);

        // two writers of $5 at stages 2 and 3: youngest wins
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd5, 0, 0, 0, n);
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd5, 0, 0, 0, n);
        idle_cycle();
        run_instr(5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0, n);
        check("dual_writer_rs", obs_rs, 32'hA000_0002);

        // $0 producer and $0 reader never interlock
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd0, 1, 0, 0, n);
        run_instr(5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0, 0, 0, n);
        check("zero_reg_holds", n, 32'd0);
        check("zero_reg_rs", obs_rs, 32'hC0DE_0001);

        // unready youngest (load) shadows a ready older ALU write
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd6, 0, 0, 0, n);
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd6, 1, 0, 0, n);
        run_instr(5'd6, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0, n);
        check("shadow_holds", n, 32'd1);
        check("shadow_rs", obs_rs, 32'hA000_0002);

        // rt forwarded from the last stage (WB)
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd7, 0, 0, 0, n);
        idle_cycle();
        idle_cycle();
        run_instr(5'd0, 5'd7, 0, 1, 0, 0, 5'd0, 0, 0, 0, n);
        check("wb_fwd_rt", obs_rt, 32'hA000_0003);
        check("wb_fwd_rs", obs_rs, 32'hC0DE_0001);

        // early compare on a load result: two stalls, then stage 3
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd11, 1, 0, 0, n);
        run_instr(5'd11, 5'd0, 1, 0, 1, 0, 5'd0, 0, 0, 0, n);
        check("early_load_holds", n, 32'd2);
        check("early_load_rs", obs_rs, 32'hA000_0003);

        // load-use hazard coinciding with an exception
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd9, 1, 0, 0, n);
        run_instr(5'd9, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 1, n);
        check("exc_hold", {31'd0, obs_hold}, 32'd0);
        check("exc_bubble", {31'd0, obs_bubble}, 32'd1);
        check("exc_flush", {31'd0, obs_flush}, 32'd1);
        idle_cycle();

        // reset in the middle of a load-use stall
        do_reset();
        run_instr(5'd1, 5'd2, 1, 1, 0, 1, 5'd9, 1, 0, 0, n);
        set_instr(5'd9, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        cycle();
        check("pre_rst_hold", {31'd0, obs_hold}, 32'd1);
        rst = 1'b1;
        cycle();
        check("in_rst_hold", {31'd0, obs_hold}, 32'd0);
        check("in_rst_rs", obs_rs, 32'hC0DE_0001);
        rst = 1'b0;
        cycle();
        check("post_rst_hold", {31'd0, obs_hold}, 32'd0);
        check("post_rst_stg_valid", {29'd0, obs_sv}, 32'd0);
        check("post_rst_stall_cnt", obs_stall, 32'd0);
        check("post_rst_flush_cnt", obs_flush_cnt, 32'd0);
        idle_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
